coproc_poly_port: RTL and testbench
===================================

# coproc_poly_port

Parametrised coprocessor front-end between the MCU parallel ports and an FPGA datapath. It accepts requests over a toggle-tag handshake on asynchronous MCU pins and computes one of four W-bit polynomial operations on a single shared multiplier and adder. It returns each result with a toggling response tag. A one-entry pending buffer absorbs a back-to-back request, and a sticky flag reports any request that had to be dropped.

## Interface
- WIDTH, 8: data and result width W.
- SYNC_STAGES, 2: synchroniser depth for req_tag, req_data and req_op; must be ≥ 2.
- ADD_K, 3: W-bit constant used by the ADD stage.

- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_data  in  WIDTH  operand from the MCU port; asynchronous to clock.
- req_op  in  2  operation select; asynchronous to clock.
  - 0: ((x·x)+K)².
  - 1: x·x.
  - 2: x+K.
  - 3: x.
- req_tag  in  1  MCU toggles this once per request; asynchronous to clock.
- ovr_clr  in  1  synchronous single-cycle clear of overrun.
- rsp_data  out  WIDTH  last result; holds until the next result.
- rsp_tag  out  1  toggles once per published result.
- busy  out  1  high when state ≠ IDLE or the pending slot is valid.
- overrun  out  1  sticky; set when a request is dropped.

## Operation
- Synchronisers:
  - req_tag, req_data and req_op each pass through an identical SYNC_STAGES-deep register chain, so data stays aligned with its tag.
  - The stage outputs are tag_s, data_s and op_s.
- Edge detect: a request is defined as tag_s ≠ prev_tag. prev_tag is loaded with tag_s on every detected edge, including dropped ones.
- Datapath: one register acc[W-1:0]. All arithmetic is modulo 2^W; upper product and carry bits are discarded.
- States:
  - IDLE → capture.
  - SQ1: acc ← acc·acc.
  - ADD: acc ← acc+ADD_K.
  - SQ2: acc ← acc·acc.
  - DONE: rsp_data ← acc; rsp_tag ← ~rsp_tag.
- Capture: acc ← operand, then go to the first stage for the op.
- Stage paths per op:
  - op 0: SQ1 → ADD → SQ2 → DONE.
  - op 1: SQ1 → DONE.
  - op 2: ADD → DONE.
  - op 3: DONE.
- IDLE with an edge: capture (data_s, op_s) directly.
- Edge while in SQ1, ADD or SQ2:
  - Pending slot empty: store (data_s, op_s) in pending and set pending_v.
  - Pending slot full: drop the request and set overrun.
- DONE, leaving the state:
  - pending_v=1: capture from pending and clear pending_v. An edge in the same cycle refills pending; no overrun.
  - pending_v=0 with an edge this cycle: capture (data_s, op_s) directly.
  - Otherwise: go to IDLE.
- overrun: ovr_clr clears it. If a set event and ovr_clr occur in the same cycle, set wins.
- MCU protocol: hold req_data and req_op stable from before the req_tag toggle until rsp_tag toggles.

## Timing
- Reset values: rsp_data=0, rsp_tag=0, busy=0, overrun=0. Internally: state=IDLE, acc=0, pending_v=0, prev_tag=0, all sync stages 0.
- Reset mid-operation aborts immediately with no response toggle. After reset the MCU must drive req_tag=0 before it issues the first request.
- Synchroniser delay: a req_tag toggle sampled at rising edge n appears on tag_s after edge n+SYNC_STAGES-1. The capture cycle is the next cycle.
- Latency from the capture edge c to the rsp_data/rsp_tag update:
  - op 0: c+4.
  - op 1: c+2.
  - op 2: c+2.
  - op 3: c+1.
- Back-to-back issue: a pending request is captured in the DONE cycle, with no IDLE bubble.
- busy is registered and rises in the cycle after the edge is detected. It falls in the cycle after DONE when nothing is pending.
- Throughput: one request in flight plus one pending. A third edge before the first DONE is dropped.

## Test plan
- W=8, K=3, op0, x=5, single toggle: rsp_data=16 (25 → 28 → 784 mod 256). rsp_tag toggles 0→1 exactly SYNC_STAGES+4 cycles after the sampled toggle.
- op0, x=16: acc sequence 0 → 3 → 9, rsp_data=9. op1, x=20: rsp_data=144.
- op2, x=254: rsp_data=1 (wrap). op3, x=0xA5: rsp_data=0xA5 at latency c+1.
- Two toggles 3 cycles apart (op0 x=2, then op1 x=3): results 49 then 9. Two rsp_tag toggles, overrun=0, no IDLE cycle between the jobs.
- Three toggles inside one op0 job: the third is dropped and overrun=1. Pulse ovr_clr → overrun=0. Pulse ovr_clr in the same cycle as a new drop → overrun stays 1.
- Assert reset_n low in the SQ2 state: all outputs return to their reset values asynchronously. After release, op3 x=7 yields rsp_data=7 and rsp_tag=1.

Source files
------------

// File: rtl/coproc_poly_port.sv
// Polynomial coprocessor front-end: synchronised MCU toggle-tag requests,
// one shared multiplier/adder, one-entry pending slot, sticky overrun flag.
// Ports: clock, reset_n (async low); i_req_data/i_req_op/i_req_tag (async MCU),
//   i_ovr_clr; o_rsp_data, o_rsp_tag, o_busy, o_overrun.
module coproc_poly_port #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ADD_K       = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_req_data,
  input  logic [1:0]       i_req_op,
  input  logic             i_req_tag,
  input  logic             i_ovr_clr,
  output logic [WIDTH-1:0] o_rsp_data,
  output logic             o_rsp_tag,
  output logic             o_busy,
  output logic             o_overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_SQ1, S_ADD, S_SQ2, S_DONE
  } state_t;

  localparam logic [WIDTH-1:0] K = WIDTH'(ADD_K);

  logic [SYNC_STAGES-1:0]            r_tag_sync;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_data_sync;
  logic [SYNC_STAGES-1:0][1:0]       r_op_sync;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [1:0]       r_op;
  logic             r_prev_tag;
  logic             r_pend_v;
  logic [WIDTH-1:0] r_pend_data;
  logic [1:0]       r_pend_op;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_tag;
  logic             r_busy;
  logic             r_overrun;

  logic             w_tag_s;
  logic [WIDTH-1:0] w_data_s;
  logic [1:0]       w_op_s;
  logic             w_edge;
  logic [WIDTH-1:0] w_sq;
  logic [WIDTH-1:0] w_add;
  logic             w_in_op;

  assign w_tag_s  = r_tag_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];
  assign w_op_s   = r_op_sync[SYNC_STAGES-1];
  assign w_edge   = w_tag_s ^ r_prev_tag;

  // Shared arithmetic; results truncated to W bits.
  assign w_sq  = r_acc * r_acc;
  assign w_add = r_acc + K;

  assign w_in_op = (r_state == S_SQ1) ||
                   (r_state == S_ADD) ||
                   (r_state == S_SQ2);

  function automatic state_t first_st(
    input logic [1:0] op
  );
    case (op)
      2'd0, 2'd1: first_st = S_SQ1;
      2'd2:       first_st = S_ADD;
      default:    first_st = S_DONE;
    endcase
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tag_sync  <= '0;
      r_data_sync <= '0;
      r_op_sync   <= '0;
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_op        <= '0;
      r_prev_tag  <= 1'b0;
      r_pend_v    <= 1'b0;
      r_pend_data <= '0;
      r_pend_op   <= '0;
      r_rsp_data  <= '0;
      r_rsp_tag   <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      // Data and op ride the same chain depth as the tag.
      r_tag_sync  <= {r_tag_sync[SYNC_STAGES-2:0], i_req_tag};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_req_data};
      r_op_sync   <= {r_op_sync[SYNC_STAGES-2:0], i_req_op};
      // Tracks tag_s on every edge, dropped ones included.
      r_prev_tag  <= w_tag_s;

      if (i_ovr_clr)
        r_overrun <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_edge) begin
            r_acc   <= w_data_s;
            r_op    <= w_op_s;
            r_state <= first_st(w_op_s);
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        S_SQ1: begin
          r_acc   <= w_sq;
          r_state <= (r_op == 2'd0) ? S_ADD : S_DONE;
        end
        S_ADD: begin
          r_acc   <= w_add;
          r_state <= (r_op == 2'd0) ? S_SQ2 : S_DONE;
        end
        S_SQ2: begin
          r_acc   <= w_sq;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_rsp_data <= r_acc;
          r_rsp_tag  <= ~r_rsp_tag;
          if (r_pend_v) begin
            // Drain pending; a same-cycle edge refills it.
            r_acc    <= r_pend_data;
            r_op     <= r_pend_op;
            r_state  <= first_st(r_pend_op);
            r_pend_v <= w_edge;
            if (w_edge) begin
              r_pend_data <= w_data_s;
              r_pend_op   <= w_op_s;
            end
            r_busy   <= 1'b1;
          end else if (w_edge) begin
            r_acc   <= w_data_s;
            r_op    <= w_op_s;
            r_state <= first_st(w_op_s);
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Set is written after clear so it wins.
      if (w_edge && w_in_op) begin
        if (!r_pend_v) begin
          r_pend_v    <= 1'b1;
          r_pend_data <= w_data_s;
          r_pend_op   <= w_op_s;
        end else begin
          r_overrun   <= 1'b1;
        end
      end
    end
  end

  assign o_rsp_data = r_rsp_data;
  assign o_rsp_tag  = r_rsp_tag;
  assign o_busy     = r_busy;
  assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_coproc_poly_port.sv
// Directed bench for coproc_poly_port (W=8, K=3, two sync stages).
// Drives MCU-side requests and checks results, timing and overrun.
module tb_coproc_poly_port;

  logic       clock;
  logic       reset_n;
  logic [7:0] i_req_data;
  logic [1:0] i_req_op;
  logic       i_req_tag;
  logic       i_ovr_clr;
  logic [7:0] o_rsp_data;
  logic       o_rsp_tag;
  logic       o_busy;
  logic       o_overrun;

  int   n_cmp = 0;
  int   n_err = 0;
  logic et;

  coproc_poly_port #(
    .WIDTH(8),
    .SYNC_STAGES(2),
    .ADD_K(3)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .i_req_data(i_req_data),
    .i_req_op(i_req_op),
    .i_req_tag(i_req_tag),
    .i_ovr_clr(i_ovr_clr),
    .o_rsp_data(o_rsp_data),
    .o_rsp_tag(o_rsp_tag),
    .o_busy(o_busy),
    .o_overrun(o_overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] d);
    i_req_op   = op;
    i_req_data = d;
    i_req_tag  = ~i_req_tag;
  endtask

  task automatic wait_rsp(input string tag, input logic [7:0] exp);
    int k;
    k  = 0;
    et = ~et;
    while (o_rsp_tag !== et && k < 50) begin
      tick();
      k++;
    end
    chk({tag, "_tag"}, o_rsp_tag, et);
    chk(tag, o_rsp_data, exp);
  endtask

  initial begin
    reset_n    = 1'b0;
    i_req_data = '0;
    i_req_op   = '0;
    i_req_tag  = 1'b0;
    i_ovr_clr  = 1'b0;
    et         = 1'b0;
    repeat (3) @(posedge clock);
    #3 reset_n = 1'b1;
    #1;
    chk("rst_data", o_rsp_data, 0);
    chk("rst_tag", o_rsp_tag, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ovr", o_overrun, 0);
    tick(); tick();

    // op0 x=5 with exact timing: edge n sample, capture n+2, rsp n+6
    send(2'd0, 8'd5);
    tick(); tick();
    chk("t1_busy_lo", o_busy, 0);
    tick();
    chk("t1_busy_hi", o_busy, 1);
    tick(); tick(); tick();
    chk("t1_tag_early", o_rsp_tag, 0);
    tick();
    et = ~et;
    chk("t1_tag", o_rsp_tag, et);
    chk("t1_data", o_rsp_data, 16);
    chk("t1_busy_fall", o_busy, 0);
    tick(); tick();

    send(2'd0, 8'd16);
    wait_rsp("op0_x16", 8'd9);
    tick(); tick();
    send(2'd1, 8'd20);
    wait_rsp("op1_x20", 8'd144);
    tick(); tick();
    send(2'd2, 8'd254);
    wait_rsp("op2_wrap", 8'd1);
    tick(); tick();

    // op3: rsp one cycle after capture
    send(2'd3, 8'hA5);
    tick(); tick(); tick();
    chk("op3_tag_early", o_rsp_tag, et);
    tick();
    et = ~et;
    chk("op3_tag", o_rsp_tag, et);
    chk("op3_data", o_rsp_data, 8'hA5);
    tick(); tick();

    // back-to-back: second request waits in pending
    send(2'd0, 8'd2);
    tick(); tick(); tick();
    send(2'd1, 8'd3);
    tick(); tick(); tick(); tick();
    et = ~et;
    chk("b2b_tag1", o_rsp_tag, et);
    chk("b2b_data1", o_rsp_data, 49);
    chk("b2b_busy1", o_busy, 1);
    tick();
    chk("b2b_no_idle", o_busy, 1);
    tick();
    et = ~et;
    chk("b2b_tag2", o_rsp_tag, et);
    chk("b2b_data2", o_rsp_data, 9);
    chk("b2b_ovr", o_overrun, 0);
    tick(); tick();

    // three requests in one op0 job: third dropped
    send(2'd0, 8'd1);
    tick();
    send(2'd1, 8'd3);
    tick();
    send(2'd3, 8'h55);
    wait_rsp("drop_r1", 8'd16);
    wait_rsp("drop_r2", 8'd9);
    chk("drop_ovr", o_overrun, 1);
    i_ovr_clr = 1'b1;
    tick();
    i_ovr_clr = 1'b0;
    chk("ovr_clr", o_overrun, 0);
    tick(); tick();

    // clear coinciding with a drop: set wins
    send(2'd0, 8'd1);
    tick();
    send(2'd1, 8'd3);
    tick();
    send(2'd3, 8'h55);
    tick(); tick();
    chk("clr_pre", o_overrun, 0);
    i_ovr_clr = 1'b1;
    tick();
    i_ovr_clr = 1'b0;
    chk("clr_vs_set", o_overrun, 1);
    wait_rsp("clr_r1", 8'd16);
    wait_rsp("clr_r2", 8'd9);
    tick(); tick();

    // reset during SQ2
    send(2'd0, 8'd5);
    repeat (5) tick();
    #2;
    reset_n   = 1'b0;
    i_req_tag = 1'b0;
    #1;
    chk("ar_data", o_rsp_data, 0);
    chk("ar_tag", o_rsp_tag, 0);
    chk("ar_busy", o_busy, 0);
    chk("ar_ovr", o_overrun, 0);
    et = 1'b0;
    tick(); tick();
    #2 reset_n = 1'b1;
    tick();
    send(2'd3, 8'd7);
    wait_rsp("post_rst", 8'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
